// File: rtl/dawson64_arbiter.sv
// dawson64_arbiter: round-robin scheduler sharing one dawson64_if FPU between
// NUM_REQ requesters, one operation in flight at a time.
// Optional watchdog: define DAWSON_ARB_TIMEOUT_EN to recover from a hung FPU
// (answer quiet NaN, pulse fpu_reset_n low, set sticky timeout_err).
module dawson64_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*64-1:0] req_a,
    input  logic [NUM_REQ*64-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [63:0]           resp_data,
    output logic [63:0]           fpu_a,
    output logic [63:0]           fpu_b,
    output logic                  fpu_ready_in,
    input  logic [63:0]           fpu_out,
    input  logic                  fpu_ready_out,
    output logic                  fpu_reset_n,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("dawson64_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_next;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  grant;
    logic [IW-1:0]  pick;
    logic [63:0]    pick_a, pick_b;
    logic           wd_hit;

    // Round-robin search starting just after the last served requester.
    always_comb begin : p_pick
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        pick  = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    // Operand mux for the chosen requester.
    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(pick) == i) begin
                pick_a = req_a[64*i +: 64];
                pick_b = req_b[64*i +: 64];
            end
        end
    end

    // Next-state logic; RESP can be reached through a real answer or the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (fpu_ready_out || wd_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, grant bookkeeping, captured operands and result register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            grant     <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            resp_data <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        fpu_a <= pick_a;
                        fpu_b <= pick_b;
                    end
                end
                WAIT: begin
                    // A real answer on the limit cycle takes precedence over the NaN.
                    if (fpu_ready_out)  resp_data <= fpu_out;
                    else if (wd_hit)    resp_data <= QNAN;
                end
                RESP:    ptr <= grant;
                default: ;
            endcase
        end
    end

    // Handshake strobes decoded from state and the latched grant only.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state == ISSUE) req_ready[grant]  = 1'b1;
        if (state == RESP)  resp_valid[grant] = 1'b1;
    end

    assign fpu_ready_in = (state == ISSUE);
    assign busy         = (state != IDLE);

`ifdef DAWSON_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt;
    logic          wd_fired;

    assign wd_hit      = (state == WAIT) && !fpu_ready_out && (wd_cnt == CW'(TIMEOUT_CYCLES));
    assign fpu_reset_n = !((state == RESP) && wd_fired);

    // Watchdog: counts WAIT cycles, remembers a hit for the RESP cycle, sticky error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            wd_fired    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ISSUE)     wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;

            if (state == WAIT)      wd_fired <= wd_hit;
            else if (state == RESP) wd_fired <= 1'b0;

            if (wd_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign fpu_reset_n = 1'b1;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dawson64_arbiter.sv
// Testbench for dawson64_arbiter: directed scenarios plus randomized traffic,
// scored every cycle against a transaction-level reference model.
module tb_dawson64_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic              clock;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N*64-1:0]   req_a, req_b;
    logic [N-1:0]      req_ready, resp_valid;
    logic [63:0]       resp_data, fpu_a, fpu_b, fpu_out;
    logic              fpu_ready_in, fpu_ready_out, fpu_reset_n, busy, timeout_err;

    dawson64_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ready_in(fpu_ready_in),
        .fpu_out(fpu_out), .fpu_ready_out(fpu_ready_out),
        .fpu_reset_n(fpu_reset_n), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus controls ----------------
    int          rq_st [N];          // 0 idle, 1 requesting, 2 awaiting result
    logic [63:0] op_a [N];
    logic [63:0] op_b [N];
    logic [N-1:0] start_mask, withdraw_mask;
    bit          rand_en, stray_en, hang, lat_rand;
    int          lat_fix;
    bit          f_pend;
    int          f_cnt;
    logic [63:0] f_res;

    // Requesters and behavioural FPU, all driven just after the rising edge.
    initial begin
        req_valid = '0; req_a = '0; req_b = '0;
        fpu_out = '0; fpu_ready_out = 1'b0;
        f_pend = 0; f_cnt = 0; f_res = '0;
        for (int i = 0; i < N; i++) begin rq_st[i] = 0; op_a[i] = '0; op_b[i] = '0; end
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                for (int i = 0; i < N; i++) rq_st[i] = 0;
                req_valid = '0; f_pend = 0; fpu_ready_out = 1'b0;
                continue;
            end
            for (int i = 0; i < N; i++) begin
                case (rq_st[i])
                    0: if (start_mask[i] || (rand_en && $urandom_range(0, 5) == 0)) begin
                        if (!start_mask[i]) begin
                            op_a[i] = {$urandom, $urandom};
                            op_b[i] = {$urandom, $urandom};
                        end
                        start_mask[i] = 1'b0;
                        rq_st[i] = 1;
                        req_valid[i] = 1'b1;
                        req_a[64*i +: 64] = op_a[i];
                        req_b[64*i +: 64] = op_b[i];
                    end
                    1: if (req_ready[i]) begin
                        req_valid[i] = 1'b0;
                        rq_st[i] = 2;
                    end else if (withdraw_mask[i] || (rand_en && $urandom_range(0, 15) == 0)) begin
                        withdraw_mask[i] = 1'b0;
                        req_valid[i] = 1'b0;
                        rq_st[i] = 0;
                    end
                    default: if (resp_valid[i]) rq_st[i] = 0;
                endcase
            end
            fpu_ready_out = 1'b0;
            if (!fpu_reset_n) f_pend = 0;
            if (f_pend) begin
                f_cnt--;
                if (f_cnt == 0) begin
                    fpu_ready_out = 1'b1;
                    fpu_out = f_res;
                    f_pend = 0;
                end
            end else if (stray_en && !fpu_ready_in && $urandom_range(0, 3) == 0) begin
                fpu_ready_out = 1'b1;
                fpu_out = {$urandom, $urandom};
            end
            if (fpu_ready_in) begin
                f_pend = !hang;
                f_cnt  = lat_rand ? int'($urandom_range(1, 12)) : lat_fix;
                f_res  = fpu_a + fpu_b;
            end
        end
    end

    // ---------------- reference model and monitor ----------------
    int          cyc = 0;
    bit          m_act, m_to, m_err;
    int          m_ptr, m_g, m_issue, m_wait, m_resp;
    logic [63:0] m_a, m_b, m_last;
    int          g_log [$];
    int          t_grant, t_issue, t_resp;
    int          n_resp, n_busy, seen1, fpurst_lows;
    logic [63:0] r_data;

    task automatic model_reset();
        m_act = 0; m_to = 0; m_err = 0; m_ptr = N - 1; m_g = 0;
        m_issue = -1; m_wait = -1; m_resp = -1;
        m_a = '0; m_b = '0; m_last = '0;
    endtask

    initial begin
        model_reset();
        t_grant = 0; t_issue = 0; t_resp = 0;
        n_resp = 0; n_busy = 0; seen1 = 0; fpurst_lows = 0; r_data = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                check("rst_req_ready", 64'(req_ready), 64'd0);
                check("rst_resp_valid", 64'(resp_valid), 64'd0);
                check("rst_resp_data", resp_data, 64'd0);
                check("rst_fpu_a", fpu_a, 64'd0);
                check("rst_fpu_b", fpu_b, 64'd0);
                check("rst_ready_in", 64'(fpu_ready_in), 64'd0);
                check("rst_fpu_reset_n", 64'(fpu_reset_n), 64'd1);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_timeout_err", 64'(timeout_err), 64'd0);
                model_reset();
                continue;
            end
            check("req_ready", 64'(req_ready), (cyc == m_issue) ? (64'd1 << m_g) : 64'd0);
            check("fpu_ready_in", 64'(fpu_ready_in), 64'(cyc == m_issue));
            check("resp_valid", 64'(resp_valid), (cyc == m_resp) ? (64'd1 << m_g) : 64'd0);
            check("busy", 64'(busy), 64'(m_act));
            check("resp_data", resp_data, m_last);
            check("fpu_a", fpu_a, m_a);
            check("fpu_b", fpu_b, m_b);
            check("timeout_err", 64'(timeout_err), 64'(m_err));
            check("fpu_reset_n", 64'(fpu_reset_n), 64'(!(cyc == m_resp && m_to)));

            for (int i = 0; i < N; i++) if (req_ready[i]) begin g_log.push_back(i); t_issue = cyc; end
            if (resp_valid != '0) begin n_resp++; t_resp = cyc; r_data = resp_data; end
            if (busy) n_busy++;
            if (req_ready[1] || resp_valid[1]) seen1++;
            if (!fpu_reset_n) fpurst_lows++;

            if (!m_act) begin
                if (req_valid != '0) begin
                    for (int k = N; k >= 1; k--)
                        if (req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                    m_act = 1; t_grant = cyc;
                    m_issue = cyc + 1; m_wait = cyc + 2; m_resp = -1;
                    m_a = req_a[64*m_g +: 64];
                    m_b = req_b[64*m_g +: 64];
                end
            end else if (m_resp < 0 && cyc >= m_wait) begin
                if (fpu_ready_out) begin
                    m_resp = cyc + 1; m_to = 0; m_last = m_a + m_b;
                end
`ifdef DAWSON_ARB_TIMEOUT_EN
                else if (cyc - m_wait == TO) begin
                    m_resp = cyc + 1; m_to = 1; m_err = 1; m_last = QNAN;
                end
`endif
            end else if (cyc == m_resp) begin
                m_ptr = m_g; m_act = 0;
            end
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic drain(input string tag, input int limit);
        int k;
        bit quiet;
        k = 0;
        quiet = 0;
        while (!quiet && k < limit) begin
            quiet = (start_mask == '0) && !m_act;
            for (int i = 0; i < N; i++) if (rq_st[i] != 0) quiet = 0;
            if (!quiet) begin step(1); k++; end
        end
        check(tag, 64'(quiet), 64'd1);
    endtask

    initial begin
        int r0, b0, f0;
        reset_n = 1'b0;
        start_mask = '0; withdraw_mask = '0;
        rand_en = 0; stray_en = 0; hang = 0; lat_rand = 0; lat_fix = 3;
        step(3);
        reset_n = 1'b1;
        step(2);

        // Round-robin: all four held valid, twice.
        for (int i = 0; i < N; i++) begin op_a[i] = 64'(i * 3 + 1); op_b[i] = 64'(i + 100); end
        g_log.delete();
        start_mask = 4'hF;
        drain("rr_drain1", 200);
        start_mask = 4'hF;
        drain("rr_drain2", 200);
        check("rr_count", 64'(g_log.size()), 64'd8);
        foreach (g_log[i]) check("rr_order", 64'(g_log[i]), 64'(i % N));

        // Single request from requester 2, FPU latency 10.
        op_a[2] = 64'h3FF0_0000_0000_0000;
        op_b[2] = 64'h4000_0000_0000_0000;
        lat_fix = 10;
        start_mask = 4'b0100;
        drain("single_drain", 100);
        check("single_issue_lat", 64'(t_issue - t_grant), 64'd1);
        check("single_resp_lat", 64'(t_resp - t_grant), 64'd12);
        check("single_data", r_data, 64'h7FF0_0000_0000_0000);

        // Withdrawal: 1 and 3 wait behind 0, then 1 withdraws.
        lat_fix = 8;
        g_log.delete();
        seen1 = 0;
        op_a[1] = 64'h11; op_b[1] = 64'h22; op_a[3] = 64'h33; op_b[3] = 64'h44;
        start_mask = 4'b0001;
        step(2);
        start_mask = 4'b1010;
        step(2);
        withdraw_mask = 4'b0010;
        drain("wd_drain", 100);
        check("withdraw_seen1", 64'(seen1), 64'd0);
        check("withdraw_count", 64'(g_log.size()), 64'd2);
        foreach (g_log[i]) check("withdraw_order", 64'(g_log[i]), (i == 0) ? 64'd0 : 64'd3);

        // Stray FPU strobes while idle.
        r0 = n_resp; b0 = n_busy;
        stray_en = 1;
        step(20);
        stray_en = 0;
        step(1);
        check("stray_resp", 64'(n_resp - r0), 64'd0);
        check("stray_busy", 64'(n_busy - b0), 64'd0);

        // Reset during WAIT drops the operation; requester 0 wins afterwards.
        lat_fix = 12;
        start_mask = 4'b0010;
        step(5);
        r0 = n_resp;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        check("rst_dropped", 64'(n_resp - r0), 64'd0);
        g_log.delete();
        lat_fix = 4;
        start_mask = 4'b0101;
        drain("rst_drain", 100);
        check("rst_resp_count", 64'(n_resp - r0), 64'd2);
        check("rst_first_grant", 64'(g_log.size() > 0 ? g_log[0] : -1), 64'd0);

        // Randomized traffic with withdrawals and stray strobes.
        r0 = n_resp;
        rand_en = 1; lat_rand = 1; stray_en = 1;
        step(1500);
        rand_en = 0; stray_en = 0;
        drain("rand_drain", 500);
        check("rand_activity", 64'(n_resp - r0 > 20), 64'd1);
        lat_rand = 0;

`ifdef DAWSON_ARB_TIMEOUT_EN
        // Watchdog tie: answer on the limit cycle wins.
        op_a[0] = 64'h1234; op_b[0] = 64'h4321;
        lat_fix = TO + 1;
        start_mask = 4'b0001;
        drain("tie_drain", 100);
        check("tie_err", 64'(timeout_err), 64'd0);
        check("tie_data", r_data, 64'h5555);

        // Watchdog hit: FPU never answers.
        f0 = fpurst_lows;
        hang = 1;
        start_mask = 4'b0010;
        drain("hit_drain", 100);
        hang = 0;
        check("hit_lat", 64'(t_resp - t_issue), 64'(TO + 2));
        check("hit_data", r_data, QNAN);
        check("hit_err", 64'(timeout_err), 64'd1);
        check("hit_fpu_rst", 64'(fpurst_lows - f0), 64'd1);
`else
        f0 = fpurst_lows;
        check("no_fpu_rst", 64'(f0), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/dawson64_arbiter.md
# dawson64_arbiter

Round-robin scheduler that shares one `dawson64_if` floating-point unit between `NUM_REQ` independent requesters. It accepts one operand pair at a time and drives the interface's user side, which takes `ready_in` for a single cycle and then waits for `ready_out`. It returns each result to the requester that issued it, so exactly one operation is in flight at any time. An optional watchdog recovers from a hung FPU.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2–8.
- `TIMEOUT_CYCLES`, default 1023: watchdog limit in WAIT, in cycles. Used only with `DAWSON_ARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester request.
- `req_a`  in  NUM_REQ*64: operand A. Requester i uses bits [64i+63:64i].
- `req_b`  in  NUM_REQ*64: operand B, same packing as `req_a`.
- `req_ready`  out  NUM_REQ: one-hot, one-cycle accept pulse.
- `resp_valid`  out  NUM_REQ: one-hot, one-cycle result pulse.
- `resp_data`  out  64: result. Valid only while `resp_valid` is nonzero.
- `fpu_a`  out  64: operand A to the FPU interface.
- `fpu_b`  out  64: operand B to the FPU interface.
- `fpu_ready_in`  out  1: start strobe to the FPU interface.
- `fpu_out`  in  64: result from the FPU interface.
- `fpu_ready_out`  in  1: result-valid strobe from the FPU interface.
- `fpu_reset_n`  out  1: reset to the FPU interface.
- `busy`  out  1: high in every state except IDLE.
- `timeout_err`  out  1: sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state only; there is no input-to-output combinational path.
- **IDLE**
  - If any `req_valid` is high, choose grant `g` by round-robin. The search starts at `ptr+1` and wraps modulo `NUM_REQ`.
  - Capture `req_a[g]` and `req_b[g]` into internal registers, latch `g`, and go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `req_ready[g]`=1 and `fpu_ready_in`=1.
  - `fpu_a` and `fpu_b` carry the captured operands.
  - Go to WAIT.
- **WAIT**
  - `fpu_ready_in`=0. `fpu_a` and `fpu_b` hold their values.
  - On `fpu_ready_out`=1, capture `fpu_out` into `resp_data` and go to RESP.
- **RESP** (exactly 1 cycle)
  - `resp_valid[g]`=1.
  - Set `ptr`=`g` and go to IDLE.
- Requester handshake: hold `req_valid` and operands until `req_ready` is seen. Operands are sampled on the IDLE→ISSUE edge. Deasserting `req_valid` before grant withdraws the request with no side effects.
- Requester g must not re-request until its `resp_valid[g]` has pulsed.
- `fpu_ready_out` is ignored outside WAIT.
- `resp_data` holds the last captured value between responses.

## Timing
- Reset values:
  - state=IDLE, `ptr`=NUM_REQ-1, so requester 0 has first priority.
  - `req_ready`=0, `resp_valid`=0, `resp_data`=0.
  - `fpu_a`=0, `fpu_b`=0, `fpu_ready_in`=0, `fpu_reset_n`=1.
  - `busy`=0, `timeout_err`=0.
- Latency:
  - Request seen in IDLE at cycle 0: ISSUE at cycle 1, WAIT from cycle 2.
  - `fpu_ready_out` at cycle k puts RESP at k+1; IDLE follows at k+2.
  - A new grant can be made in that IDLE cycle.
- Throughput: one operation per (FPU latency + 3) cycles at most.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,… No requester waits more than NUM_REQ-1 operations.
- Reset mid-operation: the in-flight operation is dropped with no `resp_valid`. `ptr` returns to NUM_REQ-1.

## Configuration
- Macro: `DAWSON_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches `TIMEOUT_CYCLES` without `fpu_ready_out`:
    - `resp_data` is set to 64'h7FF8_0000_0000_0000 (quiet NaN).
    - `timeout_err` is set (sticky until `reset_n`).
    - `fpu_reset_n` is driven 0 for exactly the RESP cycle.
    - The block goes to RESP.
  - If `fpu_ready_out` arrives in the same cycle as the limit, the real result wins and there is no error.
- **Not defined:** no counter is built. `timeout_err` is tied 0, `fpu_reset_n` is tied 1, and WAIT lasts until `fpu_ready_out`.

## Test plan
- **Single request.** Requester 2 only, a=0x3FF0000000000000, b=0x4000000000000000, FPU model latency 10 → `req_ready[2]` at cycle 1, `fpu_ready_in` for 1 cycle, `resp_valid[2]` with the model result at cycle 12.
- **Round-robin.** All 4 requesters held valid → grant order 0,1,2,3,0. Each `resp_valid` goes to the matching index with that requester's result.
- **Withdrawal.** Requester 1 drops `req_valid` before grant while requester 3 is valid → only 3 is granted; no `req_ready[1]` or `resp_valid[1]` ever.
- **Stray strobe.** `fpu_ready_out` pulsed while in IDLE → no state change, `resp_valid` stays 0.
- **Reset mid-operation.** `reset_n` asserted during WAIT → all outputs at reset values, no response. The next request from requester 0 is granted first.
- **Watchdog hit (macro defined).** FPU never answers, `TIMEOUT_CYCLES`=16 → RESP 17 cycles after WAIT entry, `resp_data`=0x7FF8000000000000, `timeout_err`=1, `fpu_reset_n` low 1 cycle.
- **Watchdog tie (macro defined).** Answer arrives on the limit cycle → real data returned, `timeout_err`=0.
